reg_file_sb: RTL and testbench

Parametrised successor to the single-cycle CPU register file, built for the pipelined core. Two combinational read ports, two synchronous write ports, and a per-register pending scoreboard. Write port A takes single-cycle ALU/load writeback. Write port B takes writeback from long-latency units (multiply/divide) and retires the scoreboard entry; decode uses the pending flags to stall.

---
 rtl/reg_file_sb_if.sv | 42 ++++
 rtl/reg_file_sb.sv | 104 ++++++++++
 tb/tb_reg_file_sb.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_sb_if.sv
//------------------------------------------------------------------------------
// reg_file_sb_if
// Read, write, issue and status bundle for the scoreboarded register file.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface reg_file_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] read_addr_1;
    logic [ADDR_W-1:0] read_addr_2;
    logic [DATA_W-1:0] read_data_1;
    logic [DATA_W-1:0] read_data_2;
    logic              pending_1;
    logic              pending_2;
    logic              reg_write;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic              ll_wr_en;
    logic [ADDR_W-1:0] ll_wr_addr;
    logic [DATA_W-1:0] ll_wr_data;
    logic              ll_issue_en;
    logic [ADDR_W-1:0] ll_issue_addr;
    logic [ADDR_W:0]   pending_cnt;
    logic              sb_err;

    modport master (
        output read_addr_1, read_addr_2, reg_write, write_addr, write_data,
               ll_wr_en, ll_wr_addr, ll_wr_data, ll_issue_en, ll_issue_addr,
        input  read_data_1, read_data_2, pending_1, pending_2, pending_cnt, sb_err
    );

    modport slave (
        input  read_addr_1, read_addr_2, reg_write, write_addr, write_data,
               ll_wr_en, ll_wr_addr, ll_wr_data, ll_issue_en, ll_issue_addr,
        output read_data_1, read_data_2, pending_1, pending_2, pending_cnt, sb_err
    );
endinterface

`default_nettype wire

// File: rtl/reg_file_sb.sv
//------------------------------------------------------------------------------
// reg_file_sb
// 2R/2W register file with per-register pending scoreboard for long-latency ops.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to reads.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  wire logic    clk,
    input  wire logic    reset,
    reg_file_sb_if.slave bus
);
    localparam int C_NREG  = 1 << ADDR_W;
    localparam int C_CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0]  r_regs [C_NREG];
    logic [C_NREG-1:0]  r_pending;
    logic [C_CNT_W-1:0] r_pending_cnt;
    logic               r_sb_err;

    logic w_wa_ok, w_wb_ok, w_is_ok;
    logic w_is_pend, w_wb_pend, w_same_set_clr;
    logic w_inc, w_dec, w_err;

    logic [ADDR_W-1:0] w_raddr [2];
    logic [DATA_W-1:0] w_rdata [2];
    logic              w_rpend [2];

    function automatic logic f_usable(input logic [ADDR_W-1:0] a);
        return !(ZERO_REG != 0 && a == '0);
    endfunction

    assign w_wa_ok = bus.reg_write   && f_usable(bus.write_addr);
    assign w_wb_ok = bus.ll_wr_en    && f_usable(bus.ll_wr_addr);
    assign w_is_ok = bus.ll_issue_en && f_usable(bus.ll_issue_addr);

    assign w_is_pend      = r_pending[bus.ll_issue_addr];
    assign w_wb_pend      = r_pending[bus.ll_wr_addr];
    assign w_same_set_clr = w_is_ok && w_wb_ok && (bus.ll_issue_addr == bus.ll_wr_addr);

    // Set wins over clear on the same address, so the count only moves when a bit flips.
    assign w_inc = w_is_ok && !w_is_pend;
    assign w_dec = w_wb_ok && w_wb_pend && !w_same_set_clr;

    assign w_err = (w_wa_ok && w_wb_ok && (bus.write_addr == bus.ll_wr_addr))
                 | (w_is_ok && w_is_pend && !w_same_set_clr)
                 | (w_wb_ok && !w_wb_pend);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < C_NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_pending     <= '0;
            r_pending_cnt <= '0;
            r_sb_err      <= 1'b0;
        end else begin
            // Port B is assigned last so it wins a same-address collision.
            if (w_wa_ok) r_regs[bus.write_addr] <= bus.write_data;
            if (w_wb_ok) r_regs[bus.ll_wr_addr] <= bus.ll_wr_data;
            if (w_wb_ok) r_pending[bus.ll_wr_addr]    <= 1'b0;
            if (w_is_ok) r_pending[bus.ll_issue_addr] <= 1'b1;
            r_pending_cnt <= r_pending_cnt + C_CNT_W'(w_inc) - C_CNT_W'(w_dec);
            r_sb_err      <= r_sb_err | w_err;
        end
    end

    assign w_raddr[0] = bus.read_addr_1;
    assign w_raddr[1] = bus.read_addr_2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rdata[p] = r_regs[w_raddr[p]];
            w_rpend[p] = r_pending[w_raddr[p]];
`ifdef REGFILE_BYPASS_EN
            if (w_wb_ok && bus.ll_wr_addr == w_raddr[p]) begin
                w_rdata[p] = bus.ll_wr_data;
            end else if (w_wa_ok && bus.write_addr == w_raddr[p]) begin
                w_rdata[p] = bus.write_data;
            end
            if (w_wb_ok && bus.ll_wr_addr == w_raddr[p] &&
                !(w_is_ok && bus.ll_issue_addr == w_raddr[p])) begin
                w_rpend[p] = 1'b0;
            end
`endif
            if (!f_usable(w_raddr[p])) w_rdata[p] = '0;
        end
    end

    assign bus.read_data_1 = w_rdata[0];
    assign bus.read_data_2 = w_rdata[1];
    assign bus.pending_1   = w_rpend[0];
    assign bus.pending_2   = w_rpend[1];
    assign bus.pending_cnt = r_pending_cnt;
    assign bus.sb_err      = r_sb_err;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_sb.sv
//------------------------------------------------------------------------------
// tb_reg_file_sb
// Directed stimulus with a queue-based scoreboard checked on the falling edge.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_reg_file_sb;
    localparam int K_RD1 = 0, K_RD2 = 1, K_P1 = 2, K_P2 = 3, K_CNT = 4, K_ERR = 5;
    localparam int C_TIMEOUT = 100000;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    bit   r_done;
    exp_t q[$];

    reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) bus_if ();

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic exp_push(input int k, input logic [31:0] v, input string tag);
        exp_t e;
        e.kind = k;
        e.exp  = v;
        e.tag  = tag;
        q.push_back(e);
    endtask

    task automatic check_now(input logic [31:0] act, input logic [31:0] exp, input string tag);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.reg_write   = 1'b0;
        bus_if.ll_wr_en    = 1'b0;
        bus_if.ll_issue_en = 1'b0;
    endtask

    // Monitor: outputs are stable mid-cycle, so drain all expectations at negedge.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.kind)
                K_RD1:   act = bus_if.read_data_1;
                K_RD2:   act = bus_if.read_data_2;
                K_P1:    act = 32'(bus_if.pending_1);
                K_P2:    act = 32'(bus_if.pending_2);
                K_CNT:   act = 32'(bus_if.pending_cnt);
                default: act = 32'(bus_if.sb_err);
            endcase
            n_tests++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", e.tag, act, e.exp);
            end
        end
    end

    initial begin
        #(C_TIMEOUT);
        if (!r_done) begin
            n_fail++;
            $display("FAIL timeout: simulation did not finish within %0d time units", C_TIMEOUT);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    initial begin
        r_done  = 1'b0;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        bus_if.read_addr_1   = '0;
        bus_if.read_addr_2   = '0;
        bus_if.write_addr    = '0;
        bus_if.write_data    = '0;
        bus_if.ll_wr_addr    = '0;
        bus_if.ll_wr_data    = '0;
        bus_if.ll_issue_addr = '0;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
        #1;
        check_now(32'(bus_if.pending_cnt), 32'h0, "reset_now_cnt");
        check_now(32'(bus_if.sb_err),      32'h0, "reset_now_err");
        check_now(bus_if.read_data_1,      32'h0, "reset_now_rd1");
        check_now(bus_if.read_data_2,      32'h0, "reset_now_rd2");

        // Reset state across every address
        for (int i = 0; i < 32; i++) begin
            bus_if.read_addr_1 = 5'(i);
            bus_if.read_addr_2 = 5'(31 - i);
            exp_push(K_RD1, 32'h0, "reset_rd1");
            exp_push(K_RD2, 32'h0, "reset_rd2");
            exp_push(K_P1,  32'h0, "reset_p1");
            exp_push(K_P2,  32'h0, "reset_p2");
            step();
        end
        exp_push(K_CNT, 32'h0, "reset_cnt");
        exp_push(K_ERR, 32'h0, "reset_err");
        step();

        // Register 0 ignores writes and issues
        bus_if.reg_write     = 1'b1;
        bus_if.write_addr    = 5'd0;
        bus_if.write_data    = 32'hFFFF_FFFF;
        bus_if.ll_issue_en   = 1'b1;
        bus_if.ll_issue_addr = 5'd0;
        bus_if.read_addr_1   = 5'd0;
        exp_push(K_RD1, 32'h0, "r0_same_cycle");
        step();
        idle_inputs();
        exp_push(K_RD1, 32'h0, "r0_read");
        exp_push(K_P1,  32'h0, "r0_pending");
        exp_push(K_CNT, 32'h0, "r0_cnt");
        exp_push(K_ERR, 32'h0, "r0_err");
        step();

        // Issue r3 then r7
        bus_if.ll_issue_en   = 1'b1;
        bus_if.ll_issue_addr = 5'd3;
        step();
        bus_if.ll_issue_addr = 5'd7;
        bus_if.read_addr_1   = 5'd3;
        exp_push(K_P1,  32'h1, "iss3_p1");
        exp_push(K_CNT, 32'h1, "iss3_cnt");
        step();
        idle_inputs();
        bus_if.read_addr_2 = 5'd7;
        exp_push(K_P2,  32'h1, "iss7_p2");
        exp_push(K_CNT, 32'h2, "iss7_cnt");
        exp_push(K_ERR, 32'h0, "iss7_err");
        step();

        // Back-to-back: port B retires r3 while r3 is issued again
        bus_if.ll_wr_en      = 1'b1;
        bus_if.ll_wr_addr    = 5'd3;
        bus_if.ll_wr_data    = 32'h0000_00A5;
        bus_if.ll_issue_en   = 1'b1;
        bus_if.ll_issue_addr = 5'd3;
        exp_push(K_P1, 32'h1, "b2b_p1_same_cycle");
        step();
        idle_inputs();
        exp_push(K_RD1, 32'h0000_00A5, "b2b_rd1");
        exp_push(K_P1,  32'h1, "b2b_p1");
        exp_push(K_CNT, 32'h2, "b2b_cnt");
        exp_push(K_ERR, 32'h0, "b2b_err");
        step();

        // Retire r7 alone
        bus_if.ll_wr_en   = 1'b1;
        bus_if.ll_wr_addr = 5'd7;
        bus_if.ll_wr_data = 32'h0000_0077;
`ifdef REGFILE_BYPASS_EN
        exp_push(K_P2,  32'h0, "ret7_p2_same_cycle");
        exp_push(K_RD2, 32'h0000_0077, "ret7_rd2_same_cycle");
`else
        exp_push(K_P2,  32'h1, "ret7_p2_same_cycle");
        exp_push(K_RD2, 32'h0, "ret7_rd2_same_cycle");
`endif
        step();
        idle_inputs();
        exp_push(K_RD2, 32'h0000_0077, "ret7_rd2");
        exp_push(K_P2,  32'h0, "ret7_p2");
        exp_push(K_CNT, 32'h1, "ret7_cnt");
        exp_push(K_ERR, 32'h0, "ret7_err");
        step();

        // Port A write to r9 observed in the same cycle
        bus_if.reg_write   = 1'b1;
        bus_if.write_addr  = 5'd9;
        bus_if.write_data  = 32'h0000_0055;
        bus_if.read_addr_1 = 5'd9;
`ifdef REGFILE_BYPASS_EN
        exp_push(K_RD1, 32'h0000_0055, "byp_rd1_same_cycle");
`else
        exp_push(K_RD1, 32'h0, "byp_rd1_same_cycle");
`endif
        step();
        idle_inputs();
        exp_push(K_RD1, 32'h0000_0055, "byp_rd1_next");
        exp_push(K_ERR, 32'h0, "byp_err");
        step();

        // Port A/B collision on r5: B wins, sticky error
        bus_if.reg_write   = 1'b1;
        bus_if.write_addr  = 5'd5;
        bus_if.write_data  = 32'hDEAD_BEEF;
        bus_if.ll_wr_en    = 1'b1;
        bus_if.ll_wr_addr  = 5'd5;
        bus_if.ll_wr_data  = 32'h1234_5678;
        step();
        idle_inputs();
        bus_if.read_addr_1 = 5'd5;
        exp_push(K_RD1, 32'h1234_5678, "coll_rd1");
        exp_push(K_ERR, 32'h1, "coll_err");
        step();
        exp_push(K_ERR, 32'h1, "coll_err_sticky");
        step();

        // Issue r4, then reset mid-cycle
        bus_if.ll_issue_en   = 1'b1;
        bus_if.ll_issue_addr = 5'd4;
        step();
        idle_inputs();
        bus_if.read_addr_2 = 5'd4;
        exp_push(K_P2,  32'h1, "iss4_p2");
        exp_push(K_CNT, 32'h2, "iss4_cnt");
        step();
        reset = 1'b1;
        exp_push(K_P2,  32'h0, "rst_p2");
        exp_push(K_CNT, 32'h0, "rst_cnt");
        exp_push(K_ERR, 32'h0, "rst_err");
        exp_push(K_RD2, 32'h0, "rst_rd2");
        step();
        reset = 1'b0;
        bus_if.read_addr_1 = 5'd5;
        exp_push(K_RD1, 32'h0, "post_rst_rd1");
        step();

        r_done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
